// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time divider: down-counter that pulses tick for one cycle every CLKS_PER_BIT cycles.
// clear restarts a full bit period so the first tick lands CLKS_PER_BIT cycles later.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == '0)) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0) && !clear;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: frames a strobed byte as start, 8 data bits LSB first, optional parity
// and 1-2 stop bits. TC and TX are registered so nothing combinational reaches the pins.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high, TC high, waiting for write_enable
// ST_START  | start bit (TX low) for one bit time
// ST_DATA   | data bits 0..7, one bit time each
// ST_PARITY | parity bit of the latched byte, one bit time
// ST_STOP   | stop bit(s), TX high, then back to idle
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       write_enable,
    output logic       TC,
    output logic       TX
);

    localparam logic HAS_PARITY = (PARITY != PAR_NONE);
    localparam logic LAST_STOP  = (STOP_BITS == 2);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q;
    logic       par_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       tx_q, tx_d;
    logic       tc_q, tc_d;
    logic       load, shift_en, baud_clear, tick;
    logic       par_calc;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    // Parity is captured together with the byte, so later changes on data cannot leak in.
    assign par_calc = (PARITY == PAR_ODD) ? ~(^data) : (^data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            tc_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            tc_q       <= tc_d;
            if (load) begin
                shift_q <= data;
                par_q   <= par_calc;
            end else if (shift_en) begin
                shift_q <= {1'b0, shift_q[7:1]};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        tc_d       = tc_q;
        load       = 1'b0;
        shift_en   = 1'b0;
        baud_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                tc_d = 1'b1;
                if (write_enable) begin
                    load       = 1'b1;
                    baud_clear = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    tc_d       = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        if (HAS_PARITY) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_en  = 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        tc_d    = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                tc_d    = 1'b1;
            end
        endcase
    end

    assign TX = tx_q;
    assign TC = tc_q;

endmodule
